// File: rtl/floo_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// floo_mem_arb_pkg
// Shared types and constants for the memory transaction arbiter.
//   arb_state_e    : request-side FSM state (IDLE / LOCKED)
//   StatsCntWidth  : width of each per-requester stall statistics counter
// ---------------------------------------------------------------------------
package floo_mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned StatsCntWidth = 32;

endpackage : floo_mem_arb_pkg

// File: rtl/floo_mem_rr_prio.sv
// ---------------------------------------------------------------------------
// floo_mem_rr_prio
// Round-robin priority encoder: picks the first set bit of `eligible` at or
// after index `ptr`, wrapping around modulo NumReq.
// Ports:
//   eligible    in  NumReq    candidate vector
//   ptr         in  IdxWidth  highest-priority index this cycle
//   grant_idx   out IdxWidth  selected index (0 when nothing is eligible)
//   grant_valid out 1         at least one candidate is eligible
// ---------------------------------------------------------------------------
module floo_mem_rr_prio
  import floo_mem_arb_pkg::*;
#(
  parameter  int unsigned NumReq   = 4,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   eligible,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] grant_idx,
  output logic                grant_valid
);

  // Walk the offsets from farthest to nearest so the nearest eligible
  // index (smallest offset from ptr) is the last one written and wins.
  always_comb begin : pick
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NumReq)) begin
        idx = idx - int'(NumReq);
      end
      if (eligible[IdxWidth'(idx)]) begin
        grant_idx   = IdxWidth'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule : floo_mem_rr_prio

// File: rtl/floo_mem_txn_arbiter.sv
// ---------------------------------------------------------------------------
// floo_mem_txn_arbiter
// Shares one memory request/response port between NumReq requesters.
// Requests are arbitrated round-robin; each requester may have at most
// MaxTxns transactions outstanding. Responses are steered back by source
// index on a purely combinational path.
//
// Optional feature: define FLOO_MEM_TXN_ARB_STATS_EN to add stall_cnt_o,
// one saturating 32-bit counter per requester counting cycles in which the
// requester is valid but out of credits.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    per-requester request handshake
//   req_payload_i          packed request payloads (requester i at slice i)
//   mem_req_*              arbitrated memory request (valid/ready/payload/src)
//   mem_rsp_*              memory response (valid/ready/src/payload)
//   rsp_valid_o/ready_i    per-requester response handshake
//   rsp_payload_o          response payload broadcast to all requesters
//   outstanding_o          packed per-requester outstanding counters
//   stall_cnt_o            (stats build only) packed stall counters
// ---------------------------------------------------------------------------
module floo_mem_txn_arbiter
  import floo_mem_arb_pkg::*;
#(
  parameter  int unsigned NumReq       = 4,
  parameter  int unsigned MaxTxns      = 4,
  parameter  int unsigned PayloadWidth = 64,
  parameter  int unsigned RspWidth     = 64,
  localparam int unsigned IdxWidth     = $clog2(NumReq),
  localparam int unsigned CntWidth     = $clog2(MaxTxns + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq*PayloadWidth-1:0]   req_payload_i,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i,
  output logic [PayloadWidth-1:0]          mem_req_payload_o,
  output logic [IdxWidth-1:0]              mem_req_src_o,
  input  logic                             mem_rsp_valid_i,
  output logic                             mem_rsp_ready_o,
  input  logic [IdxWidth-1:0]              mem_rsp_src_i,
  input  logic [RspWidth-1:0]              mem_rsp_payload_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [RspWidth-1:0]              rsp_payload_o,
  output logic [NumReq*CntWidth-1:0]       outstanding_o
`ifdef FLOO_MEM_TXN_ARB_STATS_EN
  ,
  output logic [NumReq*StatsCntWidth-1:0]  stall_cnt_o
`endif
);

  arb_state_e          state_reg;
  logic [IdxWidth-1:0] ptr_reg;
  logic [IdxWidth-1:0] grant_reg;

  logic [NumReq-1:0]       eligible;
  logic [NumReq-1:0]       rsp_hs_vec;
  logic [IdxWidth-1:0]     rr_idx;
  logic                    rr_valid;
  logic [IdxWidth-1:0]     grant_idx;
  logic                    req_valid_int;
  logic                    req_hs;
  logic [PayloadWidth-1:0] payload_arr [NumReq];

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] v);
    if (int'(v) == int'(NumReq) - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  floo_mem_rr_prio #(
    .NumReq (NumReq)
  ) u_rr_prio (
    .eligible    (eligible),
    .ptr         (ptr_reg),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  // While LOCKED the grant is frozen so payload/src stay stable under
  // backpressure; in IDLE the encoder result is used in the same cycle.
  always_comb begin
    grant_idx     = rr_idx;
    req_valid_int = rr_valid;
    if (state_reg == LOCKED) begin
      grant_idx     = grant_reg;
      req_valid_int = 1'b1;
    end
  end

  // Outputs are held quiet while reset is asserted, even if requesters
  // keep driving valid.
  assign mem_req_valid_o   = rst_ni & req_valid_int;
  assign req_hs            = mem_req_valid_o & mem_req_ready_i;
  assign mem_req_src_o     = grant_idx;
  assign mem_req_payload_o = payload_arr[grant_idx];
  assign rsp_payload_o     = mem_rsp_payload_i;

  // Out-of-range source indices (non power-of-two NumReq) simply see ready 0.
  always_comb begin
    mem_rsp_ready_o = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (mem_rsp_src_i == IdxWidth'(i)) begin
        mem_rsp_ready_o = rst_ni & rsp_ready_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rr_valid) begin
            if (mem_req_ready_i) begin
              ptr_reg <= wrap_inc(rr_idx);
            end else begin
              grant_reg <= rr_idx;
              state_reg <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (mem_req_ready_i) begin
            ptr_reg   <= wrap_inc(grant_reg);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    logic [CntWidth-1:0] cnt_reg;
    logic [CntWidth-1:0] cnt_next;
    logic                inc;
    logic                dec;

    assign payload_arr[gi] = req_payload_i[gi*PayloadWidth +: PayloadWidth];
    assign eligible[gi]    = req_valid_i[gi] & (cnt_reg < CntWidth'(MaxTxns));
    assign req_ready_o[gi] = req_hs & (grant_idx == IdxWidth'(gi));
    assign rsp_valid_o[gi] = rst_ni & mem_rsp_valid_i & (mem_rsp_src_i == IdxWidth'(gi));
    assign rsp_hs_vec[gi]  = rsp_valid_o[gi] & rsp_ready_i[gi];
    assign outstanding_o[gi*CntWidth +: CntWidth] = cnt_reg;

    // A response to an already-empty counter is ignored rather than
    // allowed to wrap.
    assign inc = req_ready_o[gi];
    assign dec = rsp_hs_vec[gi] & (cnt_reg != '0);

    always_comb begin
      cnt_next = cnt_reg;
      case ({inc, dec})
        2'b10:   cnt_next = cnt_reg + 1'b1;
        2'b01:   cnt_next = cnt_reg - 1'b1;
        default: cnt_next = cnt_reg;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

`ifdef FLOO_MEM_TXN_ARB_STATS_EN
    logic [StatsCntWidth-1:0] stall_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_reg <= '0;
      end else if (req_valid_i[gi] && (cnt_reg == CntWidth'(MaxTxns)) && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end

    assign stall_cnt_o[gi*StatsCntWidth +: StatsCntWidth] = stall_reg;
`endif

`ifndef SYNTHESIS
    // A response handshake must never target a requester with no
    // outstanding transactions.
    rsp_underflow_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(rsp_hs_vec[gi] && (cnt_reg == '0))
    );
`endif
  end

`ifndef SYNTHESIS
  // Once granted under backpressure the requester must hold its valid.
  locked_valid_held_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_reg == LOCKED) |-> req_valid_i[grant_reg]
  );
`endif

endmodule : floo_mem_txn_arbiter
